sysa_feeder: RTL and testbench
==============================

// Module: sysa_feeder
// PURPOSE
//   Upstream input stage of the N x N systolic array. Buffers row vectors of N
//   signed 8-bit activations from a valid/ready source, applies the triangular
//   skew (lane i delayed i steps), and drives the array's left-edge data and
//   global enable. After the last row of a batch it injects zero rows so that
//   all partial sums drain out of the bottom edge, then pulses done.
// PARAMETERS
//   N      3  array dimension: lanes per row vector, skew depth N-1
//   DEPTH  4  row-buffer entries; power of 2, >= 2
// PORTS
//   clk       in   1    clock
//   rst       in   1    synchronous reset, active-low
//   s_valid   in   1    source row valid
//   s_ready   out  1    buffer can accept a row (= !full, registered state only)
//   s_data    in   8*N  row vector; lane i = s_data[8i+7:8i]
//   s_last    in   1    row is the last of its batch
//   arr_en    out  1    array step enable (one systolic step per high cycle)
//   arr_in    out  8*N  skewed left-edge data; lane i -> array row i
//   busy      out  1    FSM not IDLE or buffer non-empty
//   done      out  1    one-cycle pulse: batch fully drained
// BEHAVIOUR
//   - Reset (rst=0 at a clk edge): buffer emptied, skew regs zeroed, FSM=IDLE;
//     arr_en=0, arr_in=0, done=0, busy=0, s_ready=1. Applies mid-batch too:
//     in-flight rows are discarded, no done pulse.
//   - Push: s_valid&&s_ready at edge t stores {s_data,s_last}. No push when full.
//   - Push and pop in the same cycle are both honoured; count unchanged.
//   - FSM states: IDLE, STREAM, FLUSH.
//     IDLE  : buffer non-empty -> STREAM (no pop this cycle).
//     STREAM: buffer non-empty -> pop, advance; popped s_last=1 -> FLUSH.
//             buffer empty -> no advance (bubble), stay in STREAM.
//     FLUSH : advance with zero row each cycle; count FLUSH_LEN = 2*N-1 advances,
//             then done=1 for one cycle, -> IDLE. Pushes still accepted; no pops.
//   - Advance: skew stage k of lane i shifts; arr_en registered = advance.
//     No advance -> arr_en=0 and arr_in/skew hold (array frozen, alignment kept).
//   - Latency: row pushed at edge t, buffer non-empty at t -> lane 0 on arr_in
//     after edge t+2 (IDLE entry adds one cycle); lane i appears i advances later.
//   - Data is passed unmodified (no arithmetic); zero rows are 8'h00 per lane.
//   - Counters: rd/wr pointers log2(DEPTH) bits, wrap naturally; occupancy
//     log2(DEPTH)+1 bits. Flush counter ceil(log2(2N)) bits.
// CONFIGURATION
//   SYSA_FEED_PERF_EN defined: extra port stall_cnt out 32 -- counts cycles in
//     STREAM with empty buffer; saturates at 32'hFFFF_FFFF; cleared by reset only.
//   Not defined: port absent, no counter logic; all other behaviour identical.
// STRUCTURE
//   - sysa_pkg: DATA_W=8, FSM state encoding (IDLE/STREAM/FLUSH), function
//     flush_len(N)=2*N-1; shared with the output-side collector.
//   - Sub-module sysa_feed_fifo: DEPTH x (8*N+1) synchronous FIFO, full/empty,
//     same clk/rst convention. Skew line and FSM live in sysa_feeder.
// TESTING
//   1 Reset: hold rst=0 3 cycles with s_valid=1 -> s_ready=1, arr_en=0,
//     arr_in=0, busy=0, no push stored.
//   2 Single row {3,2,1} with s_last=1, N=3 -> arr_en high 1+5 cycles; lane0
//     sees 1,0,0..; lane1 0,2,0..; lane2 0,0,3..; done pulses once after 6th step.
//   3 Back-to-back 3 rows (1s,2s,3s), last on 3rd -> diagonal skew exact;
//     after drain array out1..3 match reference matmul for w=identity.
//   4 Backpressure: push 5 rows with no pop possible (hold in FLUSH of earlier
//     batch) -> s_ready falls after 4th push, rises the cycle after first pop.
//   5 Source gap: valid low 2 cycles mid-batch -> arr_en low 2 cycles, arr_in
//     held, final results unchanged vs gapless run; with PERF_EN stall_cnt=2.
//   6 Reset mid-FLUSH -> done never pulses, busy=0 next cycle, next batch
//     produces correct results.

Source files
------------

// File: rtl/sysa_pkg.sv
// Shared definitions for the systolic-array feeder and the output-side collector.
package sysa_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } fsm_state_e;

  // Zero-row advances needed to drain every partial sum out of an n x n array
  function automatic int unsigned flush_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/sysa_feed_fifo.sv
// Synchronous first-word-fall-through row buffer for the systolic feeder.
module sysa_feed_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally; occupancy has one extra bit to tell full from empty
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/sysa_feeder.sv
// Left-edge feeder of the N x N systolic array: buffers rows, skews lanes, drains with zero rows.
// Optional stall_cnt performance port when SYSA_FEED_PERF_EN is defined.
module sysa_feeder
  import sysa_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W*N-1:0]   s_data,
  input  logic                  s_last,
  output logic                  arr_en,
  output logic [DATA_W*N-1:0]   arr_in,
  output logic                  busy,
  output logic                  done
`ifdef SYSA_FEED_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned ROW_W     = DATA_W * N;
  localparam int unsigned FLUSH_LEN = flush_len(N);
  localparam int unsigned CNT_W     = $clog2(2 * N);

  fsm_state_e       state;
  fsm_state_e       next_state;
  logic [CNT_W-1:0] flush_cnt;
  logic [ROW_W:0]   rd_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_c;
  logic             pop_c;
  logic             advance_c;
  logic             zero_row_c;
  logic             done_c;
  logic             rd_last_c;
  logic [ROW_W-1:0] row_c;

  assign s_ready   = !fifo_full;
  assign push_c    = s_valid && !fifo_full;
  assign rd_last_c = rd_entry[ROW_W];
  assign row_c     = zero_row_c ? '0 : rd_entry[ROW_W-1:0];
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  sysa_feed_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ROW_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata ({s_last, s_data}),
    .pop   (pop_c),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register; the flush counter only runs while staying in FLUSH
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ST_FLUSH && next_state == ST_FLUSH) flush_cnt <= flush_cnt + CNT_W'(1);
      else                                             flush_cnt <= '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) next_state = ST_STREAM;
      ST_STREAM: if (!fifo_empty && rd_last_c) next_state = ST_FLUSH;
      ST_FLUSH:  if (flush_cnt == CNT_W'(FLUSH_LEN)) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // FLUSH spends FLUSH_LEN cycles advancing zero rows, then one cycle signalling done
  always_comb begin
    pop_c      = 1'b0;
    advance_c  = 1'b0;
    zero_row_c = 1'b0;
    done_c     = 1'b0;
    case (state)
      ST_STREAM: begin
        pop_c     = !fifo_empty;
        advance_c = !fifo_empty;
      end
      ST_FLUSH: begin
        if (flush_cnt == CNT_W'(FLUSH_LEN)) begin
          done_c = 1'b1;
        end else begin
          advance_c  = 1'b1;
          zero_row_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      arr_en <= 1'b0;
      done   <= 1'b0;
    end else begin
      arr_en <= advance_c;
      done   <= done_c;
    end
  end

  // Lane i passes through i skew stages before reaching the array edge
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] lane_in;
    logic [DATA_W-1:0] lane_q;

    assign lane_in = row_c[i*DATA_W +: DATA_W];
    assign arr_in[i*DATA_W +: DATA_W] = lane_q;

    if (i == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (!rst)           lane_q <= '0;
        else if (advance_c) lane_q <= lane_in;
      end
    end else begin : g_skew
      logic [i*DATA_W-1:0] dly;

      always_ff @(posedge clk) begin
        if (!rst) begin
          dly    <= '0;
          lane_q <= '0;
        end else if (advance_c) begin
          dly    <= (i*DATA_W)'({dly, lane_in});
          lane_q <= dly[i*DATA_W-1 -: DATA_W];
        end
      end
    end
  end

`ifdef SYSA_FEED_PERF_EN
  // Saturating count of bubbles: streaming but nothing buffered
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state == ST_STREAM && fifo_empty && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sysa_feeder.sv
// Self-checking bench for sysa_feeder (N=3, DEPTH=4); optionally built with SYSA_FEED_PERF_EN.
module tb_sysa_feeder;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 8 * N;
  localparam int unsigned FL = 2 * N - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_last;
  logic         arr_en;
  logic [W-1:0] arr_in;
  logic         busy;
  logic         done;
`ifdef SYSA_FEED_PERF_EN
  logic [31:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  sysa_feeder #(.N(N), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .arr_en    (arr_en),
    .arr_in    (arr_in),
    .busy      (busy),
    .done      (done)
`ifdef SYSA_FEED_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  logic [W-1:0] obs[$];
  logic [W-1:0] tr_in[$];
  logic         tr_en[$];
  logic         tr_done[$];
  logic [W-1:0] batch[$];
  logic [W-1:0] exp_q[$];

  // Observe the array edge away from the active clock edge
  always @(negedge clk) begin
    tr_en.push_back(arr_en);
    tr_done.push_back(done);
    tr_in.push_back(arr_in);
    if (arr_en === 1'b1) obs.push_back(arr_in);
    if (done === 1'b1) done_cnt++;
  end

  // Array-edge view of one batch: step s carries row (s-i) on lane i, zero outside the batch
  function automatic void model_batch();
    int m;
    logic [W-1:0] v;
    m = batch.size();
    for (int s = 0; s < m + int'(FL); s++) begin
      v = '0;
      for (int i = 0; i < int'(N); i++)
        if (s - i >= 0 && s - i < m) v[i*8 +: 8] = batch[s-i][i*8 +: 8];
      exp_q.push_back(v);
    end
  endfunction

  function automatic logic [W-1:0] rand_row();
    return W'($urandom);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic l, output bit ok);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    ok      = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (s_ready === 1'b1) ok = 1'b1;
    end
    if (ok) @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (done_cnt > base) ok = 1'b1;
    end
  endtask

  task automatic clear_obs();
    obs.delete();
    tr_en.delete();
    tr_done.delete();
    tr_in.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = rand_row();
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
      n_cmp++; if (arr_en !== 1'b0)  begin n_bad++; $display("FAIL reset_arr_en: got %b want 0", arr_en); end
      n_cmp++; if (arr_in !== '0)    begin n_bad++; $display("FAIL reset_arr_in: got %h want 0", arr_in); end
      n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    rst     = 1'b1;
    cyc(2);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_nopush_busy: got %b want 0", busy); end
`ifdef SYSA_FEED_PERF_EN
    n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_single();
    int base, last_en, first_done;
    bit ok;
    clear_obs();
    batch.delete();
    batch.push_back(24'h03_02_01);
    model_batch();
    base = done_cnt;
    push(24'h03_02_01, 1'b1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_push: accepted %b want 1", ok); end
    wait_done(base, ok);
    cyc(3);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_done_timeout: seen %b want 1", ok); end
    n_cmp++; if (done_cnt - base != 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt - base); end
    n_cmp++;
    if (obs.size() != int'(FL) + 1) begin
      n_bad++; $display("FAIL single_steps: got %0d want %0d", obs.size(), FL + 1);
    end else begin
      for (int k = 0; k < obs.size(); k++) begin
        n_cmp++;
        if (obs[k] !== exp_q[k]) begin n_bad++; $display("FAIL single_step%0d: got %h want %h", k, obs[k], exp_q[k]); end
      end
    end
    last_en = -1;
    first_done = -1;
    for (int k = 0; k < tr_en.size(); k++) begin
      if (tr_en[k] === 1'b1) last_en = k;
      if (tr_done[k] === 1'b1 && first_done < 0) first_done = k;
    end
    n_cmp++;
    if (first_done != last_en + 1) begin
      n_bad++; $display("FAIL single_done_timing: done at %0d want %0d", first_done, last_en + 1);
    end
  endtask

  task automatic run_batch(input string tag, input int m, input bit ones);
    int base, got, want;
    bit ok;
    logic [W-1:0] r;
    clear_obs();
    batch.delete();
    for (int k = 0; k < m; k++) begin
      r = ones ? {3{8'(k + 1)}} : rand_row();
      batch.push_back(r);
    end
    model_batch();
    base = done_cnt;
    for (int k = 0; k < m; k++) begin
      push(batch[k], 1'(k == m - 1), ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_push%0d: accepted %b want 1", tag, k, ok); end
    end
    wait_done(base, ok);
    cyc(2);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_done_timeout: seen %b want 1", tag, ok); end
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++; $display("FAIL %s_steps: got %0d want %0d", tag, obs.size(), exp_q.size());
    end else begin
      for (int k = 0; k < obs.size(); k++) begin
        n_cmp++;
        if (obs[k] !== exp_q[k]) begin n_bad++; $display("FAIL %s_step%0d: got %h want %h", tag, k, obs[k], exp_q[k]); end
      end
      // Undo the skew and multiply by an identity weight matrix
      for (int rr = 0; rr < m; rr++)
        for (int j = 0; j < int'(N); j++) begin
          got = 0;
          want = 0;
          for (int k = 0; k < int'(N); k++) begin
            got  += int'($signed(obs[rr+k][k*8 +: 8])) * ((k == j) ? 1 : 0);
            want += int'($signed(batch[rr][k*8 +: 8])) * ((k == j) ? 1 : 0);
          end
          n_cmp++;
          if (got !== want) begin n_bad++; $display("FAIL %s_out_r%0d_c%0d: got %0d want %0d", tag, rr, j, got, want); end
        end
    end
  endtask

  task automatic test_back_to_back();
    run_batch("b2b", 3, 1'b1);
    run_batch("rand", int'($urandom_range(2, 7)), 1'b0);
  endtask

  task automatic test_backpressure();
    int base;
    bit ok, seen;
    logic [W-1:0] a;
    logic [W-1:0] b[$];
    clear_obs();
    a = rand_row();
    batch.delete();
    batch.push_back(a);
    model_batch();
    batch.delete();
    for (int k = 0; k < 5; k++) batch.push_back(rand_row());
    b = batch;
    model_batch();
    base = done_cnt;
    push(a, 1'b1, ok);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (arr_en === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_first_step: seen %b want 1", seen); end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      push(b[k], 1'b0, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_push%0d: accepted %b want 1", k, ok); end
    end
    @(negedge clk);
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full: s_ready %b want 0", s_ready); end
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = b[4];
    s_last  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (s_ready === 1'b1) seen = 1'b1;
    end
    // s_ready returns exactly on the cycle showing the first popped row
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_ready_rise: seen %b want 1", seen); end
    n_cmp++; if (arr_en !== 1'b1) begin n_bad++; $display("FAIL bp_rise_en: arr_en %b want 1", arr_en); end
    n_cmp++; if (arr_in[7:0] !== b[0][7:0]) begin n_bad++; $display("FAIL bp_rise_lane0: got %h want %h", arr_in[7:0], b[0][7:0]); end
    n_cmp++; if (done_cnt - base != 1) begin n_bad++; $display("FAIL bp_first_done: got %0d want 1", done_cnt - base); end
    @(posedge clk);
    #1 s_valid = 1'b0;
    wait_done(base + 1, ok);
    cyc(2);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_done_timeout: seen %b want 1", ok); end
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++; $display("FAIL bp_steps: got %0d want %0d", obs.size(), exp_q.size());
    end else begin
      for (int k = 0; k < obs.size(); k++) begin
        n_cmp++;
        if (obs[k] !== exp_q[k]) begin n_bad++; $display("FAIL bp_step%0d: got %h want %h", k, obs[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_gap();
    localparam int GAP = 3;
    int base, fe, le, lows;
    bit ok;
    logic [W-1:0] ref_q[$];
`ifdef SYSA_FEED_PERF_EN
    logic [31:0] st0;
`endif
    // Gapless reference run
    run_batch("nogap", 3, 1'b0);
    ref_q = obs;
    clear_obs();
    model_batch();
`ifdef SYSA_FEED_PERF_EN
    st0 = stall_cnt;
`endif
    base = done_cnt;
    push(batch[0], 1'b0, ok);
    cyc(GAP);
    push(batch[1], 1'b0, ok);
    push(batch[2], 1'b1, ok);
    wait_done(base, ok);
    cyc(2);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL gap_done_timeout: seen %b want 1", ok); end
    n_cmp++;
    if (obs.size() != ref_q.size()) begin
      n_bad++; $display("FAIL gap_steps: got %0d want %0d", obs.size(), ref_q.size());
    end else begin
      for (int k = 0; k < obs.size(); k++) begin
        n_cmp++;
        if (obs[k] !== ref_q[k] || obs[k] !== exp_q[k]) begin
          n_bad++; $display("FAIL gap_step%0d: got %h want %h", k, obs[k], exp_q[k]);
        end
      end
    end
    fe = -1;
    le = -1;
    for (int k = 0; k < tr_en.size(); k++)
      if (tr_en[k] === 1'b1) begin
        if (fe < 0) fe = k;
        le = k;
      end
    lows = 0;
    for (int k = (fe < 1 ? 1 : fe); k <= le; k++)
      if (tr_en[k] !== 1'b1) begin
        lows++;
        n_cmp++;
        if (tr_in[k] !== tr_in[k-1]) begin n_bad++; $display("FAIL gap_hold%0d: got %h want %h", k, tr_in[k], tr_in[k-1]); end
      end
    // One buffered row of slack from the IDLE entry cycle absorbs one idle source cycle
    n_cmp++; if (lows != GAP - 1) begin n_bad++; $display("FAIL gap_bubbles: got %0d want %0d", lows, GAP - 1); end
`ifdef SYSA_FEED_PERF_EN
    n_cmp++; if (stall_cnt - st0 != 32'(GAP - 1)) begin n_bad++; $display("FAIL gap_stall_cnt: got %0d want %0d", stall_cnt - st0, GAP - 1); end
`endif
  endtask

  task automatic test_reset_flush();
    int base;
    bit ok, seen;
    clear_obs();
    base = done_cnt;
    push(rand_row(), 1'b1, ok);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (arr_en === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rf_first_step: seen %b want 1", seen); end
    @(posedge clk);
    #1;
    cyc(1);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL rf_busy: got %b want 0", busy); end
    n_cmp++; if (arr_en !== 1'b0) begin n_bad++; $display("FAIL rf_arr_en: got %b want 0", arr_en); end
    n_cmp++; if (arr_in !== '0)   begin n_bad++; $display("FAIL rf_arr_in: got %h want 0", arr_in); end
`ifdef SYSA_FEED_PERF_EN
    n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL rf_stall: got %0d want 0", stall_cnt); end
`endif
    @(posedge clk);
    #1;
    cyc(15);
    n_cmp++; if (done_cnt != base) begin n_bad++; $display("FAIL rf_no_done: got %0d pulses want 0", done_cnt - base); end
    run_batch("rf_next", 3, 1'b0);
  endtask

  initial begin
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_gap();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
